// File: rtl/sam_seq_ctrl_if.sv
// Configuration handshake between a host (master) and sam_seq_ctrl (slave).
// cfg_valid/cfg_ready qualify one transfer of the n/d/capsN/len fields.
interface sam_seq_ctrl_if #(
    parameter int N_W   = 4,
    parameter int D_W   = 8,
    parameter int C_W   = 8,
    parameter int LEN_W = 10
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [N_W-1:0]   cfg_n;
    logic [D_W-1:0]   cfg_d;
    logic [C_W-1:0]   cfg_capsn;
    logic [LEN_W-1:0] cfg_len;

    modport master (output cfg_valid, cfg_n, cfg_d, cfg_capsn, cfg_len, input  cfg_ready);
    modport slave  (input  cfg_valid, cfg_n, cfg_d, cfg_capsn, cfg_len, output cfg_ready);
endinterface

// File: rtl/sam_seq_ctrl.sv
// SAM receiver sequencer: shifts a config word out on str (mode=1), idles GAP_CYC cycles, then forwards line_in (1-cycle lag) until frame done/timeout.
// cfg_ready only in IDLE, no queuing; SAM_CFG_PARITY_EN appends an even-parity bit to the config stream.
module sam_seq_ctrl #(
    parameter int N_W     = 4,
    parameter int D_W     = 8,
    parameter int C_W     = 8,
    parameter int LEN_W   = 10,
    parameter int GAP_CYC = 2,
    parameter int TMO_CYC = 255
) (
    input  logic          clk,
    input  logic          reset,
    sam_seq_ctrl_if.slave cfg,
    input  logic          line_in,
    input  logic          abort,
    output logic          mode,
    output logic          str,
    output logic          busy,
    output logic          frame_done,
    output logic          timeout_err
);
    localparam int W = N_W + D_W + C_W;
`ifdef SAM_CFG_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int SR_W = W + PAR_W;
    localparam int BC_W = $clog2(SR_W + 1);
    localparam int GC_W = $clog2(GAP_CYC + 1);
    localparam int TC_W = $clog2(TMO_CYC + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_CFG, ST_GAP, ST_RUN} state_t;

    state_t           state_q, state_d;
    logic [SR_W-1:0]  sr_q, sr_d;
    logic [BC_W-1:0]  bcnt_q, bcnt_d;
    logic [GC_W-1:0]  gcnt_q, gcnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W:0]   ecnt_q, ecnt_d;
    logic [TC_W-1:0]  idle_q, idle_d;
    logic             prev_q, prev_d;
    logic             mode_q, mode_d;
    logic             str_q, str_d;
    logic             rdy_q, rdy_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             tmo_q, tmo_d;

    logic [W-1:0]     fields;
    logic [SR_W-1:0]  word;
    logic [TC_W-1:0]  idle_inc;
    logic             rise;
    logic             chg;
    logic             to_idle;

    assign fields = {cfg.cfg_n, cfg.cfg_d, cfg.cfg_capsn};
`ifdef SAM_CFG_PARITY_EN
    assign word = {fields, ^fields};
`else
    assign word = fields;
`endif

    assign rise     = line_in & ~prev_q;
    assign chg      = line_in ^ prev_q;
    assign idle_inc = (idle_q == TC_W'(TMO_CYC)) ? idle_q : idle_q + TC_W'(1);

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        bcnt_d  = bcnt_q;
        gcnt_d  = gcnt_q;
        len_d   = len_q;
        ecnt_d  = ecnt_q;
        idle_d  = idle_q;
        prev_d  = line_in;
        mode_d  = mode_q;
        str_d   = str_q;
        rdy_d   = rdy_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        tmo_d   = 1'b0;
        to_idle = 1'b0;

        case (state_q)
            ST_IDLE: begin
                mode_d = 1'b0;
                str_d  = 1'b0;
                rdy_d  = 1'b1;
                busy_d = 1'b0;
                if (cfg.cfg_valid && rdy_q) begin
                    sr_d   = word;
                    len_d  = cfg.cfg_len;
                    ecnt_d = '0;
                    idle_d = '0;
                    if (cfg.cfg_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        // first config bit goes straight to str; the rest shift out MSB-first
                        state_d = ST_CFG;
                        mode_d  = 1'b1;
                        str_d   = word[SR_W-1];
                        sr_d    = word << 1;
                        bcnt_d  = BC_W'(1);
                        rdy_d   = 1'b0;
                        busy_d  = 1'b1;
                    end
                end
            end
            ST_CFG: begin
                if (bcnt_q == BC_W'(SR_W)) begin
                    state_d = ST_GAP;
                    mode_d  = 1'b0;
                    str_d   = 1'b0;
                    gcnt_d  = GC_W'(1);
                end else begin
                    str_d  = sr_q[SR_W-1];
                    sr_d   = sr_q << 1;
                    bcnt_d = bcnt_q + BC_W'(1);
                end
            end
            ST_GAP: begin
                if (gcnt_q == GC_W'(GAP_CYC)) begin
                    state_d = ST_RUN;
                    idle_d  = '0;
                    ecnt_d  = '0;
                end else begin
                    gcnt_d = gcnt_q + GC_W'(1);
                end
            end
            ST_RUN: begin
                str_d  = line_in;
                idle_d = chg ? '0 : idle_inc;
                if (rise) begin
                    ecnt_d = ecnt_q + (LEN_W+1)'(1);
                end
                // edge number cfg_len+1 closes the last symbol; it beats a coincident timeout
                if (rise && (ecnt_q == {1'b0, len_q})) begin
                    done_d  = 1'b1;
                    to_idle = 1'b1;
                end else if (idle_d == TC_W'(TMO_CYC)) begin
                    tmo_d   = 1'b1;
                    to_idle = 1'b1;
                end
            end
            default: begin
                to_idle = 1'b1;
            end
        endcase

        if (abort && (state_q != ST_IDLE)) begin
            to_idle = 1'b1;
            done_d  = 1'b0;
            tmo_d   = 1'b0;
        end

        if (to_idle) begin
            state_d = ST_IDLE;
            mode_d  = 1'b0;
            str_d   = 1'b0;
            rdy_d   = 1'b1;
            busy_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            bcnt_q  <= '0;
            gcnt_q  <= '0;
            len_q   <= '0;
            ecnt_q  <= '0;
            idle_q  <= '0;
            prev_q  <= 1'b0;
            mode_q  <= 1'b0;
            str_q   <= 1'b0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            bcnt_q  <= bcnt_d;
            gcnt_q  <= gcnt_d;
            len_q   <= len_d;
            ecnt_q  <= ecnt_d;
            idle_q  <= idle_d;
            prev_q  <= prev_d;
            mode_q  <= mode_d;
            str_q   <= str_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tmo_q   <= tmo_d;
        end
    end

    assign cfg.cfg_ready = rdy_q;
    assign mode          = mode_q;
    assign str           = str_q;
    assign busy          = busy_q;
    assign frame_done    = done_q;
    assign timeout_err   = tmo_q;
endmodule

// File: tb/tb_sam_seq_ctrl.sv
// Bench for sam_seq_ctrl: directed vector table, reset sequences, and random transactions
// whose expected trace comes from scanning the line pattern for edges and flat stretches.
module tb_sam_seq_ctrl;
    localparam int N_W = 4, D_W = 8, C_W = 8, LEN_W = 10, GAP_CYC = 2, TMO_CYC = 255;
`ifdef SAM_CFG_PARITY_EN
    localparam int SR_W = N_W + D_W + C_W + 1;
`else
    localparam int SR_W = N_W + D_W + C_W;
`endif
    localparam int R0   = SR_W + GAP_CYC + 1;
    localparam int PLEN = 600;
    localparam int K_DONE = 1, K_TMO = 2, K_ABORT = 3, K_ZERO = 4;

    typedef struct {
        logic [3:0] n;
        logic [7:0] d;
        logic [7:0] c;
        logic [9:0] len;
        int         pat;
        int         ph;
        int         ix;
        int         kind;
        int         ej;
    } vec_t;

    logic clk = 1'b0;
    logic reset, line_in, abort, mode, str, busy, frame_done, timeout_err;

    sam_seq_ctrl_if #(.N_W(N_W), .D_W(D_W), .C_W(C_W), .LEN_W(LEN_W)) cfg_if ();

    sam_seq_ctrl #(.N_W(N_W), .D_W(D_W), .C_W(C_W), .LEN_W(LEN_W),
                   .GAP_CYC(GAP_CYC), .TMO_CYC(TMO_CYC)) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg         (cfg_if),
        .line_in     (line_in),
        .abort       (abort),
        .mode        (mode),
        .str         (str),
        .busy        (busy),
        .frame_done  (frame_done),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    bit lpat [PLEN];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks passed %0d of %0d", n_pass, n_chk);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input int id, input int cyc, input logic [5:0] exp);
        logic [5:0] act;
        act = {cfg_if.cfg_ready, busy, mode, str, frame_done, timeout_err};
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL txn%0d cycle%0d {rdy,busy,mode,str,done,tmo}: got %b expected %b", id, cyc, act, exp);
    endtask

    function automatic logic [SR_W-1:0] cfg_word(input logic [3:0] n, input logic [7:0] d, input logic [7:0] c);
        logic [19:0] f;
        f = {n, d, c};
`ifdef SAM_CFG_PARITY_EN
        begin
            int ones;
            ones = 0;
            for (int i = 0; i < 20; i++) ones += int'(f[i]);
            return {f, 1'(ones % 2)};
        end
`else
        return f;
`endif
    endfunction

    task automatic fill_pat(input int kind);
        for (int j = 0; j < PLEN; j++) begin
            case (kind)
                0:       lpat[j] = ((j % 4) != 3);
                2:       lpat[j] = ((j % 2) == 0);
                default: lpat[j] = 1'b0;
            endcase
        end
    endtask

    // Outcome of a run: index of the (len+1)-th rising edge, or of the sample that
    // completes TMO_CYC samples with no change, whichever comes first.
    task automatic ref_run(input int len, output int kind, output int end_j);
        int rises, last_chg;
        bit p;
        rises = 0; last_chg = -1; p = 1'b0;
        kind = K_TMO; end_j = PLEN - 1;
        for (int j = 0; j < PLEN; j++) begin
            if (lpat[j] != p) last_chg = j;
            if (lpat[j] && !p) begin
                rises++;
                if (rises == len + 1) begin kind = K_DONE; end_j = j; return; end
            end
            if (j - last_chg == TMO_CYC) begin kind = K_TMO; end_j = j; return; end
            p = lpat[j];
        end
    endtask

    task automatic txn(input int id, input logic [3:0] n, input logic [7:0] d, input logic [7:0] c,
                       input logic [9:0] len, input int ph, input int ix, input int kind,
                       input int end_j, input bit noisy);
        logic [SR_W-1:0] w;
        logic [5:0] e;
        int ab_c, end_c, wt;
        w = cfg_word(n, d, c);
        wt = 0;
        while (cfg_if.cfg_ready !== 1'b1 && wt < 20) begin step(); wt++; end
        n_chk++;
        if (cfg_if.cfg_ready === 1'b1) n_pass++;
        else $display("FAIL txn%0d cfg_ready wait: got %b expected 1", id, cfg_if.cfg_ready);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_n = n; cfg_if.cfg_d = d; cfg_if.cfg_capsn = c; cfg_if.cfg_len = len;
        abort = noisy ? 1'($urandom % 2) : 1'b0;
        step();
        cfg_if.cfg_valid = 1'b0;
        abort = 1'b0;
        if (kind == K_ZERO) begin
            chk(id, 1, 6'b100010);
            step();
            chk(id, 2, 6'b100000);
            return;
        end
        ab_c  = (ph == 1) ? ix : (ph == 2) ? R0 + ix : 0;
        end_c = (ph != 0) ? ab_c + 1 : R0 + end_j + 1;
        for (int cy = 1; cy <= end_c + 1; cy++) begin
            if (cy == end_c)      e = {4'b1000, 1'(kind == K_DONE), 1'(kind == K_TMO)};
            else if (cy > end_c)  e = 6'b100000;
            else if (cy <= SR_W)  e = {3'b011, w[SR_W-cy], 2'b00};
            else if (cy < R0)     e = 6'b010000;
            else                  e = {3'b010, (cy == R0) ? 1'b0 : lpat[cy-R0-1], 2'b00};
            chk(id, cy, e);
            line_in = (cy >= R0 && cy < end_c) ? lpat[cy-R0] : 1'b0;
            abort   = (cy == ab_c);
            if (noisy && cy < end_c) begin
                cfg_if.cfg_valid = 1'($urandom % 2);
                cfg_if.cfg_n = 4'($urandom); cfg_if.cfg_d = 8'($urandom);
                cfg_if.cfg_capsn = 8'($urandom); cfg_if.cfg_len = 10'($urandom);
            end else begin
                cfg_if.cfg_valid = 1'b0;
            end
            step();
        end
        abort = 1'b0;
    endtask

    initial begin
        vec_t tv [9];
        logic [SR_W-1:0] w0;
        logic [3:0] rn;
        logic [7:0] rd, rc;
        logic [9:0] rl;
        int k, kd, ej, ph, ix;

        tv[0] = '{4'hA, 8'h35, 8'hC1, 10'd3, 0, 0, 0,           K_DONE,  12};
        tv[1] = '{4'hA, 8'h35, 8'hC1, 10'd3, 1, 0, 0,           K_TMO,   254};
        tv[2] = '{4'hA, 8'h35, 8'hC1, 10'd3, 0, 1, 7,           K_ABORT, 0};
        tv[3] = '{4'h5, 8'hFF, 8'h00, 10'd1, 2, 0, 0,           K_DONE,  2};
        tv[4] = '{4'hF, 8'hFF, 8'hFF, 10'd2, 0, 0, 0,           K_DONE,  8};
        tv[5] = '{4'hA, 8'h35, 8'hC1, 10'd0, 0, 0, 0,           K_ZERO,  0};
        tv[6] = '{4'h3, 8'h5A, 8'hA5, 10'd5, 0, 2, 3,           K_ABORT, 0};
        tv[7] = '{4'h1, 8'h80, 8'h01, 10'd3, 0, 2, 12,          K_ABORT, 0};
        tv[8] = '{4'h6, 8'h0F, 8'hF0, 10'd4, 0, 1, SR_W + 1,    K_ABORT, 0};

        reset = 1'b1; line_in = 1'b0; abort = 1'b0;
        cfg_if.cfg_valid = 1'b0; cfg_if.cfg_n = '0; cfg_if.cfg_d = '0;
        cfg_if.cfg_capsn = '0; cfg_if.cfg_len = '0;
        step(); step();
        chk(0, 0, 6'b000000);
        reset = 1'b0;
        step();
        chk(0, 1, 6'b100000);

        // reset in the middle of the config shift
        w0 = cfg_word(4'hA, 8'h35, 8'hC1);
        cfg_if.cfg_valid = 1'b1; cfg_if.cfg_n = 4'hA; cfg_if.cfg_d = 8'h35;
        cfg_if.cfg_capsn = 8'hC1; cfg_if.cfg_len = 10'd3;
        step();
        cfg_if.cfg_valid = 1'b0;
        step(); step(); step(); step();
        chk(1, 5, {3'b011, w0[SR_W-5], 2'b00});
        reset = 1'b1;
        step();
        chk(1, 6, 6'b000000);
        reset = 1'b0;
        step();
        chk(1, 7, 6'b100000);

        for (int i = 0; i < 9; i++) begin
            fill_pat(tv[i].pat);
            txn(10 + i, tv[i].n, tv[i].d, tv[i].c, tv[i].len, tv[i].ph, tv[i].ix,
                tv[i].kind, tv[i].ej, 1'b0);
        end

        for (int t = 0; t < 24; t++) begin
            rn = 4'($urandom); rd = 8'($urandom); rc = 8'($urandom);
            rl = 10'($urandom_range(1, 6));
            k  = $urandom_range(4, 100);
            lpat[0] = 1'($urandom);
            for (int j = 1; j < PLEN; j++) begin
                if (j >= k) lpat[j] = 1'b0;
                else        lpat[j] = (($urandom % 3) == 0) ? ~lpat[j-1] : lpat[j-1];
            end
            ref_run(int'(rl), kd, ej);
            ph = 0; ix = 0;
            case ($urandom % 6)
                0: begin ph = 1; ix = $urandom_range(1, SR_W + GAP_CYC); end
                1: begin ph = 2; ix = $urandom_range(0, ej); end
                2: begin rl = 10'd0; kd = K_ZERO; end
                default: ;
            endcase
            if (ph != 0) kd = K_ABORT;
            txn(100 + t, rn, rd, rc, rl, ph, ix, kd, ej, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
